counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, sets the count and limit width in bits.
REQ-002 clock  input  1  sole clock; all state updates on posedge.
REQ-003 clear_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  run request, level; sampled in IDLE, held high until done is acknowledged.
REQ-005 stop  input  1  abort request; highest priority.
REQ-006 pause  input  1  hold request; freezes count while high.
REQ-007 periodic  input  1  mode: 1 = auto-reload, 0 = one-shot.
REQ-008 limit  input  WIDTH  terminal count value.
REQ-009 Q  output  WIDTH  current count.
REQ-010 busy  output  1  high in RUN or HOLD.
REQ-011 done  output  1  registered one-cycle terminal pulse.
REQ-012 state  output  2  current FSM state, for debug.

Function
REQ-013 FSM states SHALL be IDLE, RUN, HOLD and DONE.
REQ-014 IDLE: Q=0; start=1 at edge k -> RUN, latch limit into limit_r and periodic into mode_r, Q=0 after edge k.
REQ-015 RUN, no stop/pause, Q!=limit_r: Q increments by 1 per edge.
REQ-016 Terminal event: RUN, Q==limit_r, stop=0, pause=0, at the next edge.
REQ-017 Terminal with mode_r=1: Q->0, stay in RUN, done=1 for the following cycle.
REQ-018 Terminal with mode_r=0: Q holds limit_r, go to DONE, done=1 for the following cycle.
REQ-019 Latency: start sampled at edge k gives Q=L after edge k+L and done high during the cycle after edge k+L+1.
REQ-020 DONE: Q holds limit_r until start=0 is sampled, then IDLE with Q=0 on that edge (req/ack handshake).
REQ-021 Priority per edge: stop > pause > terminal > increment.
REQ-022 stop=1 in RUN, HOLD or DONE -> IDLE, Q=0, no done pulse; stop in IDLE is ignored.
REQ-023 pause=1 in RUN -> HOLD with Q frozen, even when Q==limit_r (the terminal event is deferred).
REQ-024 pause=0 in HOLD -> RUN; counting resumes from the frozen Q.
REQ-025 limit and periodic changes while not in IDLE SHALL be ignored until the next start.
REQ-026 limit_r=0: first RUN cycle is terminal; periodic mode gives done every cycle with Q stuck at 0.
REQ-027 Arithmetic is unsigned modulo 2^WIDTH; limit_r <= 2^WIDTH-1 guarantees the terminal is reached before natural wrap.
REQ-028 start held high in IDLE after the DONE handshake SHALL NOT occur (start was low); start high on return from a stop restarts on the next edge.
REQ-029 done SHALL never be high for two consecutive cycles except in periodic mode with limit_r=0.

Reset
REQ-030 clear_n low, asynchronously: state=IDLE, Q=0, done=0, busy=0, limit_r=0, mode_r=0.
REQ-031 Reset asserted mid-RUN or mid-DONE SHALL abort without a done pulse.
REQ-032 Release is synchronous to clock; the first start is sampled on the first edge with clear_n high.

Structure
REQ-033 Shared package counter_ctrl_pkg SHALL hold the state encoding (IDLE=00, RUN=01, HOLD=10, DONE=11) and the WIDTH default.
REQ-034 Sub-module counter_core (inputs clock, clear_n, sync clear, enable; output Q) SHALL hold the counter register.
REQ-035 The FSM, limit and mode registers, compare and done logic SHALL reside in counter_ctrl.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- one-shot, limit=5, start at edge 0 -> Q 0..5, DONE with Q=5, done pulse once; start low -> IDLE, Q=0.
- periodic, limit=3 -> Q 0,1,2,3,0,1...; done every 4th cycle; busy constantly 1.
- periodic, limit=4'hF, 40 cycles -> Q wraps 15->0 via terminal, done every 16 cycles.
- pause asserted at Q==limit_r=2 for 3 cycles -> HOLD, Q=2, no done; release -> done exactly once.
- stop and pause together at Q=3 -> IDLE, Q=0, done=0; clear_n pulsed mid-RUN -> immediate Q=0, IDLE.
- limit=0 periodic -> done high every cycle, Q=0; limit changed to 7 mid-run -> no effect until restart.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter controller: state encoding and default width.
package counter_ctrl_pkg;

  localparam int unsigned CounterWidthDefault = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10,
    StDone = 2'b11
  } ctrlState_t;

endpackage

// File: rtl/counter_core.sv
// Counter register: synchronous clear has priority over increment enable.
module counter_core
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = CounterWidthDefault
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             syncClear,
  input  logic             enable,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_count;

  // Count register: async reset to zero, sync clear wins over increment.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_count <= '0;
    end else if (syncClear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign Q = r_count;

endmodule

// File: rtl/counter_ctrl.sv
// Counter controller: run/hold/done FSM around counter_core with one-shot
// and auto-reload modes, a registered terminal pulse and a start/done handshake.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = CounterWidthDefault
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  ctrlState_t       r_state;
  ctrlState_t       w_nextState;
  logic [WIDTH-1:0] r_limit;
  logic             r_mode;
  logic             r_done;
  logic [WIDTH-1:0] w_count;
  logic             w_atLimit;
  logic             w_terminal;
  logic             w_syncClear;
  logic             w_enable;
  logic             w_latch;

  counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clock    (clock),
    .clear_n  (clear_n),
    .syncClear(w_syncClear),
    .enable   (w_enable),
    .Q        (w_count)
  );

  assign w_atLimit = (w_count == r_limit);

  // Next state and counter control; priority is stop, then pause, then terminal, then increment.
  always_comb begin
    w_nextState = r_state;
    w_syncClear = 1'b0;
    w_enable    = 1'b0;
    w_terminal  = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      StIdle: begin
        w_syncClear = 1'b1;
        if (start) begin
          w_nextState = StRun;
          w_latch     = 1'b1;
        end
      end
      StRun: begin
        if (stop) begin
          w_nextState = StIdle;
          w_syncClear = 1'b1;
        end else if (pause) begin
          w_nextState = StHold;
        end else if (w_atLimit) begin
          w_terminal = 1'b1;
          if (r_mode) begin
            w_syncClear = 1'b1;
          end else begin
            w_nextState = StDone;
          end
        end else begin
          w_enable = 1'b1;
        end
      end
      StHold: begin
        if (stop) begin
          w_nextState = StIdle;
          w_syncClear = 1'b1;
        end else if (!pause) begin
          w_nextState = StRun;
        end
      end
      StDone: begin
        if (stop || !start) begin
          w_nextState = StIdle;
          w_syncClear = 1'b1;
        end
      end
      default: begin
        w_nextState = StIdle;
        w_syncClear = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Limit and mode are captured only when a run starts, so later input changes are ignored.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_limit <= '0;
      r_mode  <= 1'b0;
    end else if (w_latch) begin
      r_limit <= limit;
      r_mode  <= periodic;
    end
  end

  // Done is the terminal event delayed by one edge, giving a clean one-cycle pulse.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_terminal;
    end
  end

  assign Q     = w_count;
  assign done  = r_done;
  assign busy  = (r_state == StRun) || (r_state == StHold);
  assign state = r_state;

endmodule

// File: tb/tb_counter_ctrl.sv
// Testbench for counter_ctrl: directed scenarios plus random stimulus,
// every cycle compared against a behavioural model of the counter.
module tb_counter_ctrl;

  localparam int Width   = 4;
  localparam int Modulus = 1 << Width;

  localparam int PhIdle = 0;
  localparam int PhRun  = 1;
  localparam int PhHold = 2;
  localparam int PhDone = 3;

  logic             clock = 1'b0;
  logic             clear_n;
  logic             start;
  logic             stop;
  logic             pause;
  logic             periodic;
  logic [Width-1:0] limit;
  logic [Width-1:0] Q;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  int checkCount = 0;
  int errorCount = 0;
  int doneSeen   = 0;

  int mPhase;
  int mCount;
  int mLimit;
  bit mPeriodic;
  bit mDone;

  counter_ctrl #(
    .WIDTH(Width)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .periodic(periodic),
    .limit   (limit),
    .Q       (Q),
    .busy    (busy),
    .done    (done),
    .state   (state)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mPhase    = PhIdle;
    mCount    = 0;
    mLimit    = 0;
    mPeriodic = 1'b0;
    mDone     = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the inputs as sampled at that edge.
  task automatic modelStep();
    bit nextDone;
    nextDone = 1'b0;
    case (mPhase)
      PhIdle: begin
        mCount = 0;
        if (start) begin
          mPhase    = PhRun;
          mLimit    = int'(limit);
          mPeriodic = periodic;
        end
      end
      PhRun: begin
        if (stop) begin
          mPhase = PhIdle;
          mCount = 0;
        end else if (pause) begin
          mPhase = PhHold;
        end else if (mCount == mLimit) begin
          nextDone = 1'b1;
          if (mPeriodic) mCount = 0;
          else mPhase = PhDone;
        end else begin
          mCount = (mCount + 1) % Modulus;
        end
      end
      PhHold: begin
        if (stop) begin
          mPhase = PhIdle;
          mCount = 0;
        end else if (!pause) begin
          mPhase = PhRun;
        end
      end
      default: begin
        if (stop || !start) begin
          mPhase = PhIdle;
          mCount = 0;
        end
      end
    endcase
    mDone = nextDone;
  endtask

  task automatic compareAll();
    checkOutput("Q", 32'(Q), 32'(mCount));
    checkOutput("done", 32'(done), 32'(mDone));
    checkOutput("busy", 32'(busy), 32'((mPhase == PhRun) || (mPhase == PhHold)));
    checkOutput("state", 32'(state), 32'(mPhase));
  endtask

  // Advance one edge with the current inputs, then compare #1 after the edge.
  task automatic applyStimulus();
    @(posedge clock);
    modelStep();
    #1;
    compareAll();
    if (done === 1'b1) doneSeen++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic pulseReset();
    clear_n = 1'b0;
    #2;
    modelReset();
    compareAll();
    clear_n = 1'b1;
  endtask

  task automatic goIdle();
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b1;
    runCycles(1);
    stop = 1'b0;
  endtask

  initial begin
    clear_n  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    pause    = 1'b0;
    periodic = 1'b0;
    limit    = '0;
    modelReset();
    #3;
    compareAll();
    clear_n = 1'b1;
    runCycles(2);

    $display("[TB] one-shot limit 5");
    limit = 4'd5; periodic = 1'b0; start = 1'b1;
    doneSeen = 0;
    runCycles(9);
    checkOutput("oneshot pulses", 32'(doneSeen), 32'd1);
    checkOutput("oneshot held Q", 32'(Q), 32'd5);
    start = 1'b0;
    runCycles(2);

    $display("[TB] periodic limit 3");
    limit = 4'd3; periodic = 1'b1; start = 1'b1;
    runCycles(1);
    doneSeen = 0;
    runCycles(12);
    checkOutput("periodic3 pulses", 32'(doneSeen), 32'd3);
    goIdle();

    $display("[TB] periodic limit 15");
    limit = 4'hF; periodic = 1'b1; start = 1'b1;
    runCycles(1);
    doneSeen = 0;
    runCycles(40);
    checkOutput("periodic15 pulses", 32'(doneSeen), 32'd2);
    goIdle();

    $display("[TB] pause at terminal");
    limit = 4'd2; periodic = 1'b0; start = 1'b1;
    runCycles(3);
    pause = 1'b1;
    doneSeen = 0;
    runCycles(3);
    checkOutput("pause no pulse", 32'(doneSeen), 32'd0);
    checkOutput("pause frozen Q", 32'(Q), 32'd2);
    pause = 1'b0;
    runCycles(4);
    checkOutput("pause release pulses", 32'(doneSeen), 32'd1);
    goIdle();

    $display("[TB] stop with pause, reset mid-run");
    limit = 4'd9; periodic = 1'b0; start = 1'b1;
    runCycles(4);
    stop = 1'b1; pause = 1'b1;
    runCycles(1);
    checkOutput("stop done low", 32'(done), 32'd0);
    stop = 1'b0; pause = 1'b0;
    runCycles(3);
    pulseReset();
    runCycles(3);
    goIdle();

    $display("[TB] limit 0 periodic");
    limit = 4'd0; periodic = 1'b1; start = 1'b1;
    runCycles(1);
    doneSeen = 0;
    runCycles(6);
    checkOutput("limit0 pulses", 32'(doneSeen), 32'd6);
    limit = 4'd7;
    doneSeen = 0;
    runCycles(5);
    checkOutput("limit0 ignores change", 32'(doneSeen), 32'd5);
    goIdle();

    $display("[TB] random stimulus");
    for (int i = 0; i < 500; i++) begin
      start    = ($urandom_range(0, 3) != 0);
      stop     = ($urandom_range(0, 15) == 0);
      pause    = ($urandom_range(0, 4) == 0);
      periodic = $urandom_range(0, 1) == 1;
      limit    = Width'($urandom_range(0, Modulus - 1));
      if ($urandom_range(0, 63) == 0) pulseReset();
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
